// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_port_arbiter_pkg : shared types for the register-file write-port arbiter |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package wb_port_arbiter_pkg;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic       valid;
    creg_addr_t addr;
    u32         data;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_t;

  localparam creg_addr_t c_ZERO_REG = 5'd0;

  // A write to $zero is architecturally a no-op, so it never claims the port.
  function automatic logic is_eff_write(input logic we, input creg_addr_t addr);
    return we && (addr != c_ZERO_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_hold_buf : one-entry valid/addr/data holding register for long results  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_hold_buf
  import wb_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [4:0]  d_addr,
  input  logic [31:0] d_data,
  output logic        valid,
  output logic [4:0]  addr,
  output logic [31:0] data
);

  logic       r_valid;
  creg_addr_t r_addr;
  u32         r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= c_ZERO_REG;
      r_data  <= '0;
    end else begin
      if (load) begin
        r_valid <= 1'b1;
        r_addr  <= d_addr;
        r_data  <= d_data;
      end else if (clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid = r_valid;
  assign addr  = r_addr;
  assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_port_arbiter : shares the RF write port between writeback and long unit |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic        pend_valid,
  output logic [4:0]  pend_addr
);

  localparam logic [CNT_W-1:0] c_LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  wb_arb_state_t    r_state;
  logic [CNT_W-1:0] r_wait_cnt;

  logic       w_buf_valid;
  creg_addr_t w_buf_addr;
  u32         w_buf_data;
  logic       w_wb_eff;
  logic       w_buf_eff;
  logic       w_waw;
  logic       w_load;
  logic       w_clear;
  logic       w_stall;
  wb_req_t    w_port;

  assign w_wb_eff  = is_eff_write(wb_we, wb_waddr);
  assign w_buf_eff = is_eff_write(w_buf_valid, w_buf_addr);
  assign w_waw     = w_wb_eff && (wb_waddr == w_buf_addr);
  assign w_load    = lu_valid && lu_ready;

  wb_hold_buf u_hold_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .clear  (w_clear),
    .d_addr (lu_waddr),
    .d_data (lu_wdata),
    .valid  (w_buf_valid),
    .addr   (w_buf_addr),
    .data   (w_buf_data)
  );

  // Port mux: the pipeline owns the port unless the buffer is draining.
  always_comb begin
    w_port.valid = w_wb_eff;
    w_port.addr  = wb_waddr;
    w_port.data  = wb_wdata;
    w_stall      = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      HOLD: begin
        if (!w_wb_eff) begin
          w_port.valid = w_buf_eff;
          w_port.addr  = w_buf_addr;
          w_port.data  = w_buf_data;
          w_clear      = 1'b1;
        end else if (w_waw || !w_buf_eff) begin
          // Younger pipeline write to the same register, or a $zero entry.
          w_clear = 1'b1;
        end
      end
      FORCE: begin
        w_port.valid = w_buf_eff;
        w_port.addr  = w_buf_addr;
        w_port.data  = w_buf_data;
        w_stall      = 1'b1;
        w_clear      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state    <= HOLD;
            r_wait_cnt <= '0;
          end
        end
        HOLD: begin
          if (w_clear) begin
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == c_LAST_WAIT) begin
              r_state <= FORCE;
            end
          end
        end
        FORCE: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_we      = w_port.valid && !reset;
  assign rf_waddr   = w_port.addr;
  assign rf_wdata   = w_port.data;
  assign pipe_stall = w_stall && !reset;
  assign lu_ready   = !w_buf_valid && !reset;
  assign pend_valid = w_buf_valid;
  assign pend_addr  = w_buf_addr;

endmodule
`default_nettype wire
